// File: rtl/reader_cmd_encoder.sv
// Reader-side downlink command serializer.
// Latches a command and its fields and shifts the frame out MSB first, one bit
// per bitclk. CRC5 (Query) or CRC16 (ReqRN/Read/Write) is computed over the
// payload bits as they go out and appended at the end of the frame.
//
// Handshake: a request is taken when start=1 at a posedge while the encoder is
// not busy (IDLE, or the FINISH cycle in which done is high). That same edge
// presents the first frame bit with bitvalid=1. Every bit with bitvalid=1 is a
// frame bit; there is no back-pressure. done pulses for one cycle after the
// last bit, and start is ignored while busy=1.
module reader_cmd_encoder #(
    parameter logic [4:0]  CRC5_PRESET  = 5'b01001,
    parameter logic [15:0] CRC16_PRESET = 16'hFFFF,
    parameter int          MAX_LEN      = 66
) (
    input  logic        bitclk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  cmd_code,
    input  logic        dr,
    input  logic [1:0]  m,
    input  logic        trext,
    input  logic [1:0]  sel,
    input  logic [1:0]  session,
    input  logic        target,
    input  logic [3:0]  q,
    input  logic [2:0]  updn,
    input  logic [15:0] rn16,
    input  logic [1:0]  membank,
    input  logic [7:0]  wordptr,
    input  logic [7:0]  wordcount,
    input  logic [15:0] wdata,
    output logic        bitout,
    output logic        bitvalid,
    output logic        busy,
    output logic        done,
    output logic [6:0]  cmd_len
);

    localparam int CW = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PAYLOAD = 2'd1,
        S_CRC     = 2'd2,
        S_FINISH  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [49:0]   shreg;
    logic [CW-1:0] cnt;
    logic [6:0]    plen;
    logic          c5_en;
    logic          c16_en;
    logic [4:0]    crc5;
    logic [15:0]   crc16;

    logic [49:0]   frame;
    logic [6:0]    frame_len;
    logic [6:0]    frame_plen;
    logic          frame_c5;
    logic          frame_c16;

    logic          load;
    logic          pay_shift;
    logic          crc_shift;
    logic          finish;
    logic          pay_last;
    logic          crc_last;

    // One serial CRC5 step, poly x^5+x^3+1.
    function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic b);
        logic fb;
        fb = c[4] ^ b;
        return {c[3:0], 1'b0} ^ (fb ? 5'b01001 : 5'b00000);
    endfunction

    // One serial CRC16-CCITT step, poly x^16+x^12+x^5+1.
    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    // Assemble the left-aligned payload and its lengths from the command inputs.
    always_comb begin
        frame      = '0;
        frame_len  = 7'd0;
        frame_plen = 7'd0;
        frame_c5   = 1'b0;
        frame_c16  = 1'b0;
        unique case (cmd_code)
            3'd0: begin
                frame      = {2'b00, session, 46'd0};
                frame_plen = 7'd4;
                frame_len  = 7'd4;
            end
            3'd1: begin
                frame      = {2'b01, rn16, 32'd0};
                frame_plen = 7'd18;
                frame_len  = 7'd18;
            end
            3'd2: begin
                frame      = {4'b1000, dr, m, trext, sel, session, target, q, 33'd0};
                frame_plen = 7'd17;
                frame_len  = 7'd22;
                frame_c5   = 1'b1;
            end
            3'd3: begin
                frame      = {4'b1001, session, updn, 41'd0};
                frame_plen = 7'd9;
                frame_len  = 7'd9;
            end
            3'd4: begin
                frame      = {8'b1100_0000, 42'd0};
                frame_plen = 7'd8;
                frame_len  = 7'd8;
            end
            3'd5: begin
                frame      = {8'b1100_0001, rn16, 26'd0};
                frame_plen = 7'd24;
                frame_len  = 7'd40;
                frame_c16  = 1'b1;
            end
            3'd6: begin
                frame      = {8'b1100_0010, membank, wordptr, wordcount, rn16, 8'd0};
                frame_plen = 7'd42;
                frame_len  = 7'd58;
                frame_c16  = 1'b1;
            end
            default: begin
                frame      = {8'b1100_0011, membank, wordptr, wdata, rn16};
                frame_plen = 7'd50;
                frame_len  = 7'd66;
                frame_c16  = 1'b1;
            end
        endcase
    end

    assign pay_last = (cnt == CW'(plen - 7'd1));
    assign crc_last = (cnt == CW'(cmd_len - 7'd1));

    // State register.
    always_ff @(posedge bitclk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next state and per-edge datapath actions. FINISH is the done cycle and
    // already counts as idle, which gives the one-cycle minimum frame gap.
    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        pay_shift = 1'b0;
        crc_shift = 1'b0;
        finish    = 1'b0;
        unique case (state_q)
            S_IDLE, S_FINISH: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = S_PAYLOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PAYLOAD: begin
                if (!pay_last) begin
                    pay_shift = 1'b1;
                end else if (c5_en || c16_en) begin
                    crc_shift = 1'b1;
                    state_d   = S_CRC;
                end else begin
                    finish    = 1'b1;
                    state_d   = S_FINISH;
                end
            end
            default: begin
                if (!crc_last) begin
                    crc_shift = 1'b1;
                end else begin
                    finish    = 1'b1;
                    state_d   = S_FINISH;
                end
            end
        endcase
    end

    // Shift register, counter, CRC registers and registered outputs.
    always_ff @(posedge bitclk or posedge reset) begin
        if (reset) begin
            shreg    <= '0;
            cnt      <= '0;
            plen     <= 7'd0;
            c5_en    <= 1'b0;
            c16_en   <= 1'b0;
            crc5     <= CRC5_PRESET;
            crc16    <= CRC16_PRESET;
            bitout   <= 1'b0;
            bitvalid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cmd_len  <= 7'd0;
        end else begin
            done <= finish;
            if (load) begin
                shreg    <= {frame[48:0], 1'b0};
                bitout   <= frame[49];
                bitvalid <= 1'b1;
                busy     <= 1'b1;
                cmd_len  <= frame_len;
                plen     <= frame_plen;
                c5_en    <= frame_c5;
                c16_en   <= frame_c16;
                cnt      <= '0;
                crc5     <= frame_c5  ? crc5_step(CRC5_PRESET, frame[49])   : CRC5_PRESET;
                crc16    <= frame_c16 ? crc16_step(CRC16_PRESET, frame[49]) : CRC16_PRESET;
            end else if (pay_shift) begin
                shreg  <= {shreg[48:0], 1'b0};
                bitout <= shreg[49];
                cnt    <= cnt + 1'b1;
                if (c5_en)  crc5  <= crc5_step(crc5, shreg[49]);
                if (c16_en) crc16 <= crc16_step(crc16, shreg[49]);
            end else if (crc_shift) begin
                cnt <= cnt + 1'b1;
                if (c5_en) begin
                    bitout <= crc5[4];
                    crc5   <= {crc5[3:0], 1'b0};
                end else begin
                    bitout <= ~crc16[15];
                    crc16  <= {crc16[14:0], 1'b0};
                end
            end else if (finish) begin
                bitout   <= 1'b0;
                bitvalid <= 1'b0;
                busy     <= 1'b0;
                crc5     <= CRC5_PRESET;
                crc16    <= CRC16_PRESET;
            end
        end
    end

endmodule

// File: doc/reader_cmd_encoder.md
Name: reader_cmd_encoder

Overview:
Reader-side serializer for EPC Gen2-style downlink commands; it is the transmit counterpart of the tag-side command parser.
- Takes a command code plus field values, builds the bit sequence MSB-first, and appends CRC5 or CRC16 on the fly where required.
- Drives one bit per bitclk into the reader's PIE modulator.
- Field bit widths and total lengths match what the tag parser expects, so encoder-to-parser loopback is exact.

Parameters:
CRC5_PRESET, 5'b01001, CRC5 register preset (poly x^5+x^3+1).
CRC16_PRESET, 16'hFFFF, CRC16-CCITT register preset (poly x^16+x^12+x^5+1).
MAX_LEN, 66, longest frame in bits (Write); sizes the bit counter (7 bits).

Ports:
bitclk  in  1  bit clock; all state changes on posedge.
reset  in  1  asynchronous, active-high.
start  in  1  request; sampled only in IDLE.
cmd_code  in  3  0 QueryRep, 1 Ack, 2 Query, 3 QueryAdj, 4 Nack, 5 ReqRN, 6 Read, 7 Write.
dr  in  1  Query DR.
m  in  2  Query M.
trext  in  1  Query TRext.
sel  in  2  Query Sel.
session  in  2  Query/QueryRep/QueryAdj session.
target  in  1  Query target.
q  in  4  Query Q.
updn  in  3  QueryAdj UpDn.
rn16  in  16  handle for Ack/ReqRN/Read/Write.
membank  in  2  Read/Write memory bank.
wordptr  in  8  Read/Write word pointer.
wordcount  in  8  Read word count.
wdata  in  16  Write data.
bitout  out  1  serial bit, MSB first.
bitvalid  out  1  bitout is a frame bit.
busy  out  1  frame in progress.
done  out  1  one-cycle pulse after the last bit.
cmd_len  out  7  total bits of the latched frame.

Behaviour:
- Reset (async, immediate, including mid-frame): bitout=0, bitvalid=0, busy=0, done=0, cmd_len=0, state=IDLE, counter=0, CRC registers preset. The aborted frame is not resumed.
- States: IDLE -> PAYLOAD -> (CRC if frame has CRC) -> FINISH -> IDLE.
- Frame layouts, MSB first, with total length:
  - QueryRep: 00,session; 4 bits.
  - Ack: 01,rn16; 18 bits.
  - Query: 1000,dr,m,trext,sel,session,target,q,CRC5; 22 bits.
  - QueryAdj: 1001,session,updn; 9 bits.
  - Nack: 11000000; 8 bits.
  - ReqRN: 11000001,rn16,CRC16; 40 bits.
  - Read: 11000010,membank,wordptr,wordcount,rn16,CRC16; 58 bits.
  - Write: 11000011,membank,wordptr,wdata,rn16,CRC16; 66 bits.
- Start accept: IDLE with start=1 at posedge k.
  - Latch all fields into a 50-bit left-aligned shift register and set cmd_len.
  - Same edge: bitout=first bit, bitvalid=1, busy=1; state goes to PAYLOAD.
  - Inputs may change freely after edge k.
- PAYLOAD: each posedge shifts out the next bit.
  - Every payload bit, including the command code, is fed into the active CRC (CRC5 for Query, CRC16 for ReqRN/Read/Write) as it is presented.
  - After the last payload bit, go to CRC if the frame has one, otherwise to FINISH.
- CRC: emit crc register MSB first. CRC5 is sent true. CRC16 is sent ones-complemented.
  - Receiver residue is 0 for CRC5 and 16'h1D0F for CRC16.
  - The CRC register shifts without further feedback during this state.
- Edge k+cmd_len: bitvalid=0, busy=0, done=1 for exactly one cycle, bitout=0, CRCs preset; state goes to IDLE.
  - A start asserted during the done cycle is accepted at the following edge; the minimum gap between frames is 1 idle cycle.
- start while busy: ignored with no effect. The value of cmd_code never blocks acceptance, since all 8 codes are valid.
- Counter: 7-bit, cleared on accept, compared against cmd_len-1 to leave PAYLOAD/CRC; it never wraps.

Test Plan:
- Reset asserted mid-Read at bit 30 -> outputs 0 within the reset; next start with QueryRep session=2'b01 -> bits 0,0,0,1, cmd_len=4, done pulses at edge k+4.
- Query dr=1,m=2'b10,trext=0,sel=0,session=0,target=0,q=4'd4 -> first 17 bits 1000_1_10_0_00_00_0_0100, 22 bits total; loopback into the tag parser gives cmd_out[2], dr=1, m=2, trext=0, crc5invalid=0.
- ReqRN rn16=16'hA5C3 -> 40 bits, first 24 = 11000001_1010010111000011; tag parser gives crc16invalid=0.
- Write membank=2'b11,wordptr=8'h02,wdata=16'h1234,rn16=16'hBEEF -> 66 bits, busy for 66 cycles, single done pulse; start pulsed at bit 10 is ignored.
- Back-to-back: Nack, then start held high through done -> second frame's first bit appears at edge done+1; no bitvalid gap other than the done cycle.
- Read with one bit of the CRC field flipped in the loopback path -> tag parser sets crc16invalid=1.
